// File: rtl/key_pad_emulator.sv
// 4x4 matrix-keypad emulator: drives row sense lines from the column scan as if a
// commanded key were pressed, with contact bounce, hold time and release gap.
module key_pad_emulator #(
  parameter int unsigned CLK_PER_MS     = 100000,
  parameter int unsigned BOUNCE_TOGGLES = 4,
  parameter int unsigned BOUNCE_CYCLES  = 50000,
  parameter int unsigned GAP_MS         = 20
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] col,
  input  logic       press_req,
  input  logic [3:0] key_code,
  input  logic [7:0] hold_ms,
  input  logic       abort,
  output logic [3:0] row,
  output logic       busy,
  output logic       done,
  output logic       pressed
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] BOUNCE_IN  = 3'd1;
  localparam logic [2:0] HOLD       = 3'd2;
  localparam logic [2:0] BOUNCE_OUT = 3'd3;
  localparam logic [2:0] GAP        = 3'd4;

  localparam logic [31:0] GAP_CYCLES = 32'(GAP_MS * CLK_PER_MS);

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [7:0]  tog;
  logic [3:0]  key;
  logic [7:0]  hold;
  logic [31:0] hold_cycles;
  logic        bounce_step;
  logic        bounce_last;

  assign hold_cycles = 32'(hold) * CLK_PER_MS;
  assign bounce_step = (cnt + 32'd1 >= BOUNCE_CYCLES);
  // The exit edge is itself the final toggle, so the level lands back where it started.
  assign bounce_last = bounce_step && (32'(tog) + 32'd1 >= BOUNCE_TOGGLES);

  // Pure switch behaviour: no clock latency from column drive to row sense.
  always_comb begin
    row = '0;
    if (pressed && col[key[1:0]]) row[key[3:2]] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= IDLE;
      cnt     <= '0;
      tog     <= '0;
      key     <= '0;
      hold    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pressed <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (press_req) begin
            key     <= key_code;
            hold    <= (hold_ms == 8'd0) ? 8'd1 : hold_ms;
            busy    <= 1'b1;
            pressed <= 1'b1;
            cnt     <= '0;
            tog     <= '0;
            state   <= (BOUNCE_TOGGLES == 0) ? HOLD : BOUNCE_IN;
          end
        end
        BOUNCE_IN, BOUNCE_OUT: begin
          if (abort) begin
            pressed <= 1'b0;
            cnt     <= '0;
            tog     <= '0;
            state   <= GAP;
          end else if (bounce_step) begin
            cnt <= '0;
            if (bounce_last) begin
              tog     <= '0;
              pressed <= (state == BOUNCE_IN);
              state   <= (state == BOUNCE_IN) ? HOLD : GAP;
            end else begin
              tog     <= tog + 8'd1;
              pressed <= ~pressed;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HOLD: begin
          if (abort) begin
            pressed <= 1'b0;
            cnt     <= '0;
            state   <= GAP;
          end else if (cnt + 32'd1 >= hold_cycles) begin
            pressed <= 1'b0;
            cnt     <= '0;
            tog     <= '0;
            state   <= (BOUNCE_TOGGLES == 0) ? GAP : BOUNCE_OUT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt + 32'd1 >= GAP_CYCLES) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          tog     <= '0;
          busy    <= 1'b0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/key_pad_emulator.md
Name: key_pad_emulator

Overview:
- Synthesizable 4x4 matrix-keypad emulator; acts as the switch-matrix end of the keypad scan interface.
- Watches the column-scan drive from the keypad controller and returns row levels as if a commanded key were physically pressed.
- Models contact bounce, hold time and release gap.
- Used for board-level loopback and self-test of the keypad scan/decode path without a physical keypad.

Parameters:
- CLK_PER_MS, 100000, clk cycles per millisecond (100 MHz clk).
- BOUNCE_TOGGLES, 4, pressed-level toggles during press and release bounce; even; 0 = no bounce.
- BOUNCE_CYCLES, 50000, clk cycles between bounce toggles (0.5 ms).
- GAP_MS, 20, released time enforced after each key before the next request is accepted.

Ports:
- clk  in  1  system clock
- reset_p  in  1  asynchronous, active-high reset
- col  in  4  column scan drive from keypad controller; active-high; one-hot or zero
- press_req  in  1  start key press; sampled only in IDLE
- key_code  in  4  key to press; row index = key_code[3:2], column index = key_code[1:0]
- hold_ms  in  8  stable-pressed duration in ms; 0 treated as 1
- abort  in  1  cancel current press
- row  out  4  emulated row sense lines; active-high
- busy  out  1  emulator not in IDLE
- done  out  1  one-cycle pulse when a press sequence completes or an abort finishes
- pressed  out  1  current emulated contact state (debug)

Behaviour:
- Reset, asynchronous: state=IDLE; pressed=0; busy=0; done=0; all counters=0; latched key=0; row=0.
- row is combinational from col and registers: row = one-hot(key_row) when pressed=1 and col[key_col]=1, else 0. No clk latency from col to row; models a real switch.
- All other outputs are registered.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE:
  - press_req=1 at edge E0: latch key_code and hold_ms (0 becomes 1); go BOUNCE_IN; busy=1 from E0.
  - If BOUNCE_TOGGLES=0, go directly to HOLD.
- BOUNCE_IN: lasts BOUNCE_TOGGLES*BOUNCE_CYCLES cycles. pressed=1 on entry, toggles every BOUNCE_CYCLES cycles, exits with pressed=1 into HOLD.
- HOLD: pressed=1 for hold_ms*CLK_PER_MS cycles, then BOUNCE_OUT (or GAP if BOUNCE_TOGGLES=0).
- BOUNCE_OUT: mirror of BOUNCE_IN. pressed=0 on entry, toggles every BOUNCE_CYCLES cycles, exits with pressed=0 into GAP.
- GAP: pressed=0 for GAP_MS*CLK_PER_MS cycles. On the final edge: go IDLE, busy=0, done=1 for exactly one cycle.
- press_req while busy: ignored, not queued. Latched key and hold_ms do not change mid-sequence.
- press_req in the same cycle done is high: accepted (state is IDLE).
- abort=1 in BOUNCE_IN, HOLD or BOUNCE_OUT: next edge pressed=0, go GAP with full gap length. abort in GAP or IDLE: no effect.
- abort and press_req together in IDLE: press_req wins.
- Counters: 32-bit cycle counter cleared on every state entry; 8-bit toggle counter.
- hold_ms*CLK_PER_MS is computed at 32 bits with no overflow for the defaults.
- col with multiple bits set: row follows the rule above; only the latched column bit matters.
- Reset mid-sequence: immediate return to reset values; row drops to 0 combinationally.

Test Plan (CLK_PER_MS=10, BOUNCE_TOGGLES=4, BOUNCE_CYCLES=3, GAP_MS=2):
- Basic press: key_code=4'b0110, hold_ms=2, static col=4'b0100 -> pressed pattern 1,0,1,0 (3 cycles each, 12 cycles), then 20 cycles =1, then 0,1,0,1 (12 cycles), then 20 cycles =0. row=4'b0010 whenever pressed=1, else 0. busy high 64 cycles; done single pulse in cycle 65.
- Scan loopback: keypad controller instance scanning col; key_code=4'hB, hold_ms=5 -> controller key_valid asserts and key_value decodes to 11.
- Column mismatch: key_code=4'h3, col=4'b0001 -> row=0 during the whole HOLD; col=4'b1000 -> row=4'b0001.
- Busy rejection and hold_ms=0: press_req during HOLD is ignored (sequence unchanged, latched key unchanged). A new request with hold_ms=0 gives HOLD of 10 cycles.
- Abort: abort at the 5th HOLD cycle -> next cycle pressed=0 and row=0; GAP lasts 20 cycles; done pulses; abort issued in IDLE has no effect.
- Reset mid-BOUNCE_OUT: reset_p pulse -> row, pressed, busy and done are 0 immediately. press_req after release starts a fresh sequence with full timing.
